// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_responder_pkg                                          |
// | Purpose  : Shared constants, FSM state type and lane helpers for the       |
// |            data-memory responder.                                          |
// | Contents : DATA_MEM_NUM_LOG2 default depth, chip/write enable levels,      |
// |            big-endian lane-select encodings, state_e, sel_misaligned(),    |
// |            lane_mask().                                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package data_mem_responder_pkg;

  localparam int DATA_MEM_NUM_LOG2 = 10;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Big-endian lanes: sel[3] selects data[31:24], which lives at byte offset 00.
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the lane select is not a legal pattern or does not match the
  // byte offset of the address. An all-zero select falls into the default arm.
  function automatic logic sel_misaligned(input logic [3:0] sel, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (sel)
      SEL_B0:  bad = (off != 2'd0);
      SEL_B1:  bad = (off != 2'd1);
      SEL_B2:  bad = (off != 2'd2);
      SEL_B3:  bad = (off != 2'd3);
      SEL_H0:  bad = (off != 2'd0);
      SEL_H1:  bad = (off != 2'd2);
      SEL_W:   bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_ram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_responder_ram_bank                                     |
// | Purpose  : Word-organised RAM built from four 8-bit lanes with per-lane    |
// |            write enables; synchronous write, asynchronous read.            |
// | Ports    : clk      in  clock                                              |
// |            we_i     in  per-lane write enable, we_i[3] -> bits 31:24       |
// |            addr_i   in  word index (shared by read and write)              |
// |            wdata_i  in  write data                                         |
// |            rdata_o  out read data (combinational)                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_responder_ram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
      if (we_i[lane]) begin
        mem_q[addr_i] <= wdata_i[lane*8 +: 8];
      end
    end

    assign rdata_o[lane*8 +: 8] = mem_q[addr_i];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_responder                                              |
// | Purpose  : Responder for the MEM-stage data bus. Captures a request,       |
// |            waits WAIT_STATES cycles, then answers with a one-cycle ack     |
// |            (and err for misaligned / out-of-range accesses).               |
// | Ports    : clk, rst (sync, active-low)                                     |
// |            mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i  request  |
// |            mem_data_o, mem_ack_o, mem_err_o                       response |
// |            stallreq_o  combinational pipeline hold                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stallreq_o
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            sel_q, sel_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  rerr_q, rerr_d;

  logic                  in_err;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [3:0]            req_sel;
  logic                  req_err;
  logic [3:0]            ram_we;
  logic [31:0]           ram_rdata;

  assign in_err = (mem_sel_i == 4'b0000)
                | sel_misaligned(mem_sel_i, mem_addr_i[1:0])
                | ((mem_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);

  // With zero wait states the response is formed on the same edge that
  // captures the request, so the live inputs must be used while in IDLE.
  assign req_idx = (state_q == ST_IDLE) ? mem_addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign req_sel = (state_q == ST_IDLE) ? mem_sel_i : sel_q;
  assign req_err = (state_q == ST_IDLE) ? in_err : err_q;

  // Commit on the edge that ends RESP; a reset on that edge drops the store.
  assign ram_we = ((state_q == ST_RESP) && (we_q == WRITE_ENABLE) && !err_q && rst)
                ? sel_q : 4'b0000;

  assign stallreq_o = ((state_q == ST_IDLE) && (mem_ce_i == CHIP_ENABLE))
                    || (state_q == ST_WAIT);

  data_mem_responder_ram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (req_idx),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i == CHIP_ENABLE) begin
          idx_d   = mem_addr_i[ADDR_WIDTH+1:2];
          sel_d   = mem_sel_i;
          we_d    = mem_we_i;
          wdata_d = mem_data_i;
          err_d   = in_err;
          cnt_d   = 3'd0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == WAIT_LAST) begin
          cnt_d   = 3'd0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d   = (state_d == ST_RESP);
    rerr_d  = (state_d == ST_RESP) && req_err;
    rdata_d = rdata_q;
    if (state_d == ST_RESP) begin
      rdata_d = req_err ? 32'd0 : (ram_rdata & lane_mask(req_sel));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      rerr_q  <= rerr_d;
    end
  end

  assign mem_data_o = rdata_q;
  assign mem_ack_o  = ack_q;
  assign mem_err_o  = rerr_q;

endmodule
`default_nettype wire
